// File: rtl/spi_master_arbiter_pkg.sv
// Shared state encoding and defaults for the SPI master arbiter.
package spi_master_arbiter_pkg;

    localparam int unsigned DefaultDataWidth = 8;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StStart    = 2'd1,
        StWaitBusy = 2'd2,
        StWaitDone = 2'd3
    } arb_state_e;

endpackage

// File: rtl/spi_rr_select.sv
// Combinational round-robin picker: first asserted request at or after the pointer, wrapping.
module spi_rr_select #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned ID_WIDTH = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]    i_req,
    input  logic [ID_WIDTH-1:0] i_ptr,
    output logic                o_valid,
    output logic [ID_WIDTH-1:0] o_idx
);

    logic [ID_WIDTH-1:0] w_cand;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_cand = ID_WIDTH'((32'(i_ptr) + i) % N_REQ);
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one byte-level SPI master driver among N_REQ requesters.
// Define SPI_MASTER_ARBITER_TIMEOUT_EN to bound the wait for the driver to accept a start.
module spi_master_arbiter
    import spi_master_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned DATA_WIDTH    = DefaultDataWidth,
    parameter int unsigned ID_WIDTH      = $clog2(N_REQ),
    parameter int unsigned START_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            i_req,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [N_REQ-1:0]            i_lock,
    output logic [N_REQ-1:0]            o_ack,
    output logic [DATA_WIDTH-1:0]       o_rsp_data,
    output logic [ID_WIDTH-1:0]         o_grant_id,
    output logic                        o_busy,
    output logic                        o_err,
    output logic                        o_drv_start,
    output logic [DATA_WIDTH-1:0]       o_drv_data_in,
    input  logic [DATA_WIDTH-1:0]       i_drv_data_out,
    input  logic                        i_drv_ready
);

    arb_state_e            r_state;
    logic [ID_WIDTH-1:0]   r_ptr;
    logic [ID_WIDTH-1:0]   r_grant_id;
    logic                  r_locked;
    logic                  r_drv_start;
    logic [N_REQ-1:0]      r_ack;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [DATA_WIDTH-1:0] r_drv_data;

    logic                  w_sel_valid;
    logic [ID_WIDTH-1:0]   w_sel_idx;
    logic                  w_hold;
    logic                  w_pick_valid;
    logic [ID_WIDTH-1:0]   w_pick_idx;
    logic [DATA_WIDTH-1:0] w_pick_data;
    logic [N_REQ-1:0]      w_grant_oh;
    logic [ID_WIDTH-1:0]   w_next_ptr;
    logic                  w_timeout;

    spi_rr_select #(
        .N_REQ    (N_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_select (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_valid (w_sel_valid),
        .o_idx   (w_sel_idx)
    );

    // A lock only holds while its owner keeps requesting; otherwise round-robin takes over.
    assign w_hold       = r_locked && i_req[r_grant_id];
    assign w_pick_valid = w_hold || w_sel_valid;
    assign w_pick_idx   = w_hold ? r_grant_id : w_sel_idx;
    assign w_grant_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << r_grant_id;
    assign w_next_ptr   = (r_grant_id == ID_WIDTH'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;

    always_comb begin
        w_pick_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick_idx == ID_WIDTH'(i)) begin
                w_pick_data = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(START_TIMEOUT + 1);

    logic [CntWidth-1:0] r_cnt;
    logic                r_err;

    assign w_timeout = i_drv_ready && (r_cnt == CntWidth'(START_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (r_state == StWaitBusy) ? r_cnt + 1'b1 : '0;
            if (r_state == StWaitBusy && w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_err = r_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (START_TIMEOUT == 0);
    assign w_timeout        = 1'b0;
    assign o_err            = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_ptr       <= '0;
            r_grant_id  <= '0;
            r_locked    <= 1'b0;
            r_drv_start <= 1'b0;
            r_ack       <= '0;
            r_rsp_data  <= '0;
            r_drv_data  <= '0;
        end else begin
            r_ack       <= '0;
            r_drv_start <= 1'b0;
            case (r_state)
                StIdle: begin
                    // Skip the ack cycle so the acked requester can drop req or stage its next byte.
                    if (r_ack == '0) begin
                        r_locked <= w_hold;
                        if (w_pick_valid) begin
                            r_grant_id <= w_pick_idx;
                            r_drv_data <= w_pick_data;
                            r_state    <= StStart;
                        end
                    end
                end
                StStart: begin
                    if (r_drv_start) begin
                        r_state <= StWaitBusy;
                    end else if (i_drv_ready) begin
                        r_drv_start <= 1'b1;
                    end
                end
                StWaitBusy: begin
                    if (!i_drv_ready) begin
                        r_state <= StWaitDone;
                    end else if (w_timeout) begin
                        r_ack    <= w_grant_oh;
                        r_locked <= 1'b0;
                        r_ptr    <= w_next_ptr;
                        r_state  <= StIdle;
                    end
                end
                StWaitDone: begin
                    if (i_drv_ready) begin
                        r_rsp_data <= i_drv_data_out;
                        r_ack      <= w_grant_oh;
                        r_locked   <= i_lock[r_grant_id];
                        if (!i_lock[r_grant_id]) begin
                            r_ptr <= w_next_ptr;
                        end
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_ack         = r_ack;
    assign o_rsp_data    = r_rsp_data;
    assign o_grant_id    = r_grant_id;
    assign o_busy        = (r_state != StIdle);
    assign o_drv_start   = r_drv_start;
    assign o_drv_data_in = r_drv_data;

endmodule
